// File: rtl/rv32i_soc_top.sv
// Single-cycle RV32I core with one unified code/data RAM.
// Fetch and data read are combinational; register writeback, data store and pc
// update all happen on the same rising edge of sys_clk.
module rv32i_soc_top #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic sys_clk,
  input  logic sys_res
);

  // RAM_WORDS is expected to be a power of two so that byte addresses wrap cleanly.
  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0]   pc;
  logic [31:0]   regs [1:31];

  logic [31:0]   instr;
  logic [31:0]   rdata;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] data_idx;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   daddr;

  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1_a;
  logic [4:0]    rs2_a;
  logic [2:0]    funct3;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  logic [31:0]   imm_i;
  logic [31:0]   imm_s;
  logic [31:0]   imm_b;
  logic [31:0]   imm_u;
  logic [31:0]   imm_j;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  logic [31:0]   pc_d;
  logic          rd_we;
  logic [31:0]   rd_val;
  logic          br_take;

  // Unified main RAM: two combinational read ports, one byte-enabled write port.
  if (1) begin : ram_main
    logic [31:0] RAM [0:RAM_WORDS-1];

    assign instr = RAM[fetch_idx];
    assign rdata = RAM[data_idx];

    // Byte-lane store; contents deliberately survive reset so a preload is kept.
    always_ff @(posedge sys_clk) begin
      if (mem_we && !sys_res) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) RAM[data_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];

  assign rs1 = (rs1_a == 5'd0) ? 32'd0 : regs[rs1_a];
  assign rs2 = (rs2_a == 5'd0) ? 32'd0 : regs[rs2_a];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Word fetch: pc[1:0] ignored; both indices wrap modulo RAM_WORDS.
  assign fetch_idx = pc[AW+1:2];
  assign daddr     = rs1 + ((opcode == OpStore) ? imm_s : imm_i);
  assign data_idx  = daddr[AW+1:2];

  assign ld_byte = rdata[{daddr[1:0], 3'b000} +: 8];
  assign ld_half = daddr[1] ? rdata[31:16] : rdata[15:0];

  logic unused_daddr;
  assign unused_daddr = ^daddr[31:AW+2];

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? (a - b) : (a + b);
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Branch condition evaluation; reserved funct3 values never branch.
  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'd0:    br_take = (rs1 == rs2);
      3'd1:    br_take = (rs1 != rs2);
      3'd4:    br_take = ($signed(rs1) < $signed(rs2));
      3'd5:    br_take = ($signed(rs1) >= $signed(rs2));
      3'd6:    br_take = (rs1 < rs2);
      3'd7:    br_take = (rs1 >= rs2);
      default: br_take = 1'b0;
    endcase
  end

  // Decode/execute: next pc, writeback value and store request for this instruction.
  always_comb begin
    pc_d      = pc + 32'd4;
    rd_we     = 1'b0;
    rd_val    = 32'd0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    case (opcode)
      OpLui: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OpAuipc: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OpJal: begin
        rd_we  = 1'b1;
        rd_val = pc + 32'd4;
        pc_d   = pc + imm_j;
      end
      OpJalr: begin
        // rs1 is read combinationally before the edge, so rd == rs1 is safe.
        rd_we  = 1'b1;
        rd_val = pc + 32'd4;
        pc_d   = (rs1 + imm_i) & 32'hFFFF_FFFE;
      end
      OpBranch: begin
        if (br_take) pc_d = pc + imm_b;
      end
      OpLoad: begin
        case (funct3)
          3'd0: begin rd_we = 1'b1; rd_val = {{24{ld_byte[7]}}, ld_byte}; end
          3'd1: begin rd_we = 1'b1; rd_val = {{16{ld_half[15]}}, ld_half}; end
          3'd2: begin rd_we = 1'b1; rd_val = rdata; end
          3'd4: begin rd_we = 1'b1; rd_val = {24'd0, ld_byte}; end
          3'd5: begin rd_we = 1'b1; rd_val = {16'd0, ld_half}; end
          default: ;
        endcase
      end
      OpStore: begin
        case (funct3)
          3'd0: begin
            mem_we    = 1'b1;
            mem_be    = 4'b0001 << daddr[1:0];
            mem_wdata = {4{rs2[7:0]}};
          end
          3'd1: begin
            mem_we    = 1'b1;
            mem_be    = daddr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{rs2[15:0]}};
          end
          3'd2: begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_wdata = rs2;
          end
          default: ;
        endcase
      end
      OpImm: begin
        rd_we  = 1'b1;
        rd_val = alu(rs1, imm_i, funct3, (funct3 == 3'd5) && instr[30]);
      end
      OpReg: begin
        rd_we  = 1'b1;
        rd_val = alu(rs1, rs2, funct3, instr[30]);
      end
      default: ;  // FENCE, SYSTEM and unknown opcodes retire as no-ops
    endcase
  end

  // Architectural state: pc and x1..x31, cleared by synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_res) begin
      pc <= RESET_PC;
      for (int i = 1; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= pc_d;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_rv32i_soc_top.sv
// Bench for rv32i_soc_top: directed programs with literal expectations plus
// randomized programs compared every cycle against an instruction-level model.
module tb_rv32i_soc_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_soc_top #(
    .RAM_WORDS(4096),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .sys_clk(clk),
    .sys_res(rst)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;
  logic [31:0] m_mem  [0:4095];
  int          m_last_st = -1;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // ---------------- reference model (instruction-set level) ----------------
  task automatic model_reset();
    m_pc = 32'd0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, o2, res, addr, w, nxt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [7:0]  by;
    logic [15:0] hw;
    int          si, ss, sb, sj;
    bit          wr, t;
    ins  = m_mem[m_pc[13:2]];
    op   = ins[6:0];
    rd   = ins[11:7];
    f3   = ins[14:12];
    a    = m_regs[ins[19:15]];
    b    = m_regs[ins[24:20]];
    si   = int'($signed(ins[31:20]));
    ss   = int'($signed({ins[31:25], ins[11:7]}));
    sb   = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    sj   = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt  = m_pc + 32'd4;
    wr   = 1'b0;
    res  = 32'd0;
    case (op)
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h000}; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + sj; end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + si) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = m_pc + sb;
      end
      7'h03: begin
        addr = a + si;
        w    = m_mem[addr[13:2]];
        by   = 8'(w >> (8 * addr[1:0]));
        hw   = 16'(w >> (16 * addr[1]));
        wr   = 1'b1;
        case (f3)
          3'd0: res = {{24{by[7]}}, by};
          3'd1: res = {{16{hw[15]}}, hw};
          3'd2: res = w;
          3'd4: res = {24'd0, by};
          3'd5: res = {16'd0, hw};
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        addr = a + ss;
        w    = m_mem[addr[13:2]];
        case (f3)
          3'd0: w[8*addr[1:0] +: 8] = b[7:0];
          3'd1: w[16*addr[1] +: 16] = b[15:0];
          3'd2: w = b;
          default: ;
        endcase
        if (f3 <= 3'd2) begin
          m_mem[addr[13:2]] = w;
          m_last_st = int'(addr[13:2]);
        end
      end
      7'h13, 7'h33: begin
        o2 = (op == 7'h13) ? si : b;
        wr = 1'b1;
        case (f3)
          3'd0: res = (op == 7'h33 && ins[30]) ? a - o2 : a + o2;
          3'd1: res = a << o2[4:0];
          3'd2: res = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
          3'd3: res = (a < o2) ? 32'd1 : 32'd0;
          3'd4: res = a ^ o2;
          3'd5: res = ins[30] ? 32'($signed(a) >>> o2[4:0]) : a >> o2[4:0];
          3'd6: res = a | o2;
          default: res = a & o2;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  // ---------------- checking ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of architectural state against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut.pc !== m_pc) begin
        n_fail++;
        $display("FAIL pc @%0t: got %08h, expected %08h", $time, dut.pc, m_pc);
      end
      for (int r = 1; r < 32; r++) begin
        n_checks++;
        if (dut.regs[r] !== m_regs[r]) begin
          n_fail++;
          $display("FAIL x%0d @%0t: got %08h, expected %08h", r, $time, dut.regs[r], m_regs[r]);
        end
      end
      if (m_last_st >= 0) begin
        n_checks++;
        if (dut.ram_main.RAM[m_last_st] !== m_mem[m_last_st]) begin
          n_fail++;
          $display("FAIL ram[%0d] @%0t: got %08h, expected %08h", m_last_st, $time,
                   dut.ram_main.RAM[m_last_st], m_mem[m_last_st]);
        end
      end
    end
  end

  // ---------------- sequencing ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else model_step();
    end
  endtask

  // Loads a program into both DUT RAM and model memory while reset is held.
  task automatic run_prog(input logic [31:0] prog [$], input int cycles);
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      m_mem[i] = 32'd0;
      dut.ram_main.RAM[i] = 32'd0;
    end
    foreach (prog[i]) begin
      m_mem[i] = prog[i];
      dut.ram_main.RAM[i] = prog[i];
    end
    m_last_st = -1;
    tick(2);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(cycles);
  endtask

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rand_instr(input int len);
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          k;
    r = $urandom();
    k = int'($urandom_range(0, 10));
    case (k)
      0: return enc_u(r[19:0], rreg(), 7'h37);
      1: return enc_u(r[19:0], rreg(), 7'h17);
      2: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd1) r = {27'd0, r[4:0]};
        else if (f3 == 3'd5) r = {20'd0, 1'b0, r[10], 5'd0, r[4:0]};
        return enc_i(r, rreg(), f3, rreg(), 7'h13);
      end
      3, 4: begin
        f3 = 3'($urandom_range(0, 7));
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00;
        return enc_r(f7, rreg(), rreg(), f3, rreg());
      end
      5: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        return enc_i(r, rreg(), f3, rreg(), 7'h03);
      end
      6: return enc_s(r, rreg(), rreg(), 3'($urandom_range(0, 2)));
      7: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd4;
          3: f3 = 3'd5;
          4: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
        return enc_b(32'(($urandom_range(0, 12) - 4) * 4), rreg(), rreg(), f3);
      end
      8: return enc_j(32'($urandom_range(1, 6) * 4), rreg());
      9: return enc_i(32'($urandom_range(0, len - 1) * 4 + $urandom_range(0, 1)),
                      5'd0, 3'd0, rreg(), 7'h67);
      default: begin
        case ($urandom_range(0, 3))
          0: f7 = 7'h0F;
          1: f7 = 7'h73;
          2: f7 = 7'h7F;
          default: f7 = 7'h00;
        endcase
        return {r[31:7], f7};
      end
    endcase
  endfunction

  initial begin
    logic [31:0] p [$];

    // 1: two addis after a two-cycle reset
    p.delete();
    p.push_back(enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    p.push_back(enc_i(-32'sd7, 5'd1, 3'd0, 5'd2, 7'h13));
    run_prog(p, 2);
    lit("t1_x1", dut.regs[1], 32'd5);
    lit("t1_x2", dut.regs[2], 32'hFFFF_FFFE);
    lit("t1_pc", dut.pc, 32'h8);

    // 2: word store, sub-word loads; 6: reset mid-program keeps RAM
    p.delete();
    p.push_back(enc_u(20'h12345, 5'd1, 7'h37));
    p.push_back(enc_i(32'h678, 5'd1, 3'd0, 5'd1, 7'h13));
    p.push_back(enc_s(32'h100, 5'd1, 5'd0, 3'd2));
    p.push_back(enc_i(32'h101, 5'd0, 3'd0, 5'd2, 7'h03));
    p.push_back(enc_i(32'h102, 5'd0, 3'd5, 5'd3, 7'h03));
    run_prog(p, 3);
    rst = 1'b1;
    tick(1);
    lit("t6_pc", dut.pc, 32'h0);
    lit("t6_x1", dut.regs[1], 32'h0);
    lit("t6_ram", dut.ram_main.RAM[64], 32'h1234_5678);
    tick(2);
    lit("t6_pc_held", dut.pc, 32'h0);
    rst = 1'b0;
    tick(5);
    lit("t2_ram", dut.ram_main.RAM[64], 32'h1234_5678);
    lit("t2_lb", dut.regs[2], 32'h0000_0056);
    lit("t2_lhu", dut.regs[3], 32'h0000_1234);

    // 3: byte store overwrites one lane only
    p.delete();
    p.push_back(enc_i(-32'sd1, 5'd0, 3'd0, 5'd1, 7'h13));
    p.push_back(enc_s(32'h200, 5'd1, 5'd0, 3'd2));
    p.push_back(enc_s(32'h200, 5'd0, 5'd0, 3'd0));
    run_prog(p, 3);
    lit("t3_ram", dut.ram_main.RAM[128], 32'hFFFF_FF00);

    // 4a: bltu -1<1 not taken, blt -1<1 taken
    p.delete();
    p.push_back(enc_i(-32'sd1, 5'd0, 3'd0, 5'd1, 7'h13));
    p.push_back(enc_i(32'd1, 5'd0, 3'd0, 5'd2, 7'h13));
    p.push_back(enc_b(32'h40, 5'd2, 5'd1, 3'd6));
    p.push_back(enc_b(32'h20, 5'd2, 5'd1, 3'd4));
    run_prog(p, 3);
    lit("t4_bltu", dut.pc, 32'h0C);
    tick(1);
    lit("t4_blt", dut.pc, 32'h2C);

    // 4b: jal and jalr with rd == rs1 and odd target
    p.delete();
    repeat (4) p.push_back(32'h0000_0000);
    p.push_back(enc_j(32'd8, 5'd5));
    p.push_back(enc_i(32'd7, 5'd0, 3'd0, 5'd9, 7'h13));
    p.push_back(enc_i(32'h40, 5'd0, 3'd0, 5'd1, 7'h13));
    p.push_back(enc_i(32'd1, 5'd1, 3'd0, 5'd1, 7'h67));
    run_prog(p, 5);
    lit("t4_jal_pc", dut.pc, 32'h18);
    lit("t4_jal_x5", dut.regs[5], 32'h14);
    tick(2);
    lit("t4_jalr_pc", dut.pc, 32'h40);
    lit("t4_jalr_x1", dut.regs[1], 32'h20);
    lit("t4_skip_x9", dut.regs[9], 32'h0);

    // 5: srai sign fill, srl by 33, x0 write discarded
    p.delete();
    p.push_back(enc_u(20'h80000, 5'd1, 7'h37));
    p.push_back(enc_i(32'h41F, 5'd1, 3'd5, 5'd2, 7'h13));
    p.push_back(enc_i(32'd33, 5'd0, 3'd0, 5'd3, 7'h13));
    p.push_back(enc_i(-32'sd16, 5'd0, 3'd0, 5'd4, 7'h13));
    p.push_back(enc_r(7'h00, 5'd3, 5'd4, 3'd5, 5'd5));
    p.push_back(enc_i(32'd9, 5'd0, 3'd0, 5'd0, 7'h13));
    p.push_back(enc_i(32'd3, 5'd0, 3'd0, 5'd6, 7'h13));
    run_prog(p, 7);
    lit("t5_srai", dut.regs[2], 32'hFFFF_FFFF);
    lit("t5_srl", dut.regs[5], 32'h7FFF_FFF8);
    lit("t5_x0", dut.regs[6], 32'd3);

    // Randomized programs checked every cycle by the model comparison.
    for (int n = 0; n < 25; n++) begin
      p.delete();
      for (int i = 0; i < 48; i++) p.push_back(rand_instr(48));
      run_prog(p, 300);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
